// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory responder: funct3 access codes,
// FSM state encoding and the default array depth.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for narrow accesses: byte enables and replicated store data,
// sign/zero extension of load data, and detection of illegal size/alignment.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_write,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        reject
);

    logic signed [7:0]  rd_byte;
    logic signed [15:0] rd_half;

    always_comb begin
        rd_byte = 8'(rdata_raw >> {addr_lo, 3'b000});
        rd_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    end

    always_comb begin
        reject     = 1'b0;
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
        case (size)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = 32'(rd_byte);
            end
            F3_H: begin
                reject     = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = 32'(rd_half);
            end
            F3_W: begin
                reject  = (addr_lo != 2'b00);
                byte_en = 4'b1111;
            end
            F3_BU: begin
                reject    = is_write;
                rdata_ext = {24'h0, rd_byte};
            end
            F3_HU: begin
                reject    = is_write | addr_lo[0];
                rdata_ext = {16'h0, rd_half};
            end
            default: reject = 1'b1;
        endcase
        // Unsigned loads fall through with no enables, so a rejected access never writes.
        if (reject || !is_write) byte_en = 4'b0000;
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Unified instruction/data word array answering MemRead/MemWrite strobes from the
// multicycle control FSM, with programmable wait states and a MemReady handshake.
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Size,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        MisalignErr
);

    localparam int AW = $clog2(DEPTH);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem_array [DEPTH];
    logic [31:0] rdata_raw;
    logic [31:0] rdata_ext;
    logic [31:0] wdata_lane;
    logic [3:0]  byte_en;
    logic        reject;
    logic        mem_we;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^Address[31:AW+2];
    assign rdata_raw        = mem_array[idx_q];

    mem_lane_align u_align (
        .size       (size_q),
        .addr_lo    (lo_q),
        .is_write   (wr_q),
        .wdata      (wdata_q),
        .rdata_raw  (rdata_raw),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .reject     (reject)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    idx_d   = Address[AW+1:2];
                    lo_d    = Address[1:0];
                    wdata_d = WriteData;
                    size_d  = Size;
                    wr_d    = MemWrite;
                    cnt_d   = 4'(WAIT_CYCLES);
                    busy_d  = 1'b1;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                err_d   = reject;
                if (reject)     rdata_d = 32'h0;
                else if (!wr_q) rdata_d = rdata_ext;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Request payload is only consumed while an access is in flight.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        lo_q    <= lo_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
    end

    // Reset clears state_q asynchronously, so an aborted write can never reach RESP.
    assign mem_we = (state_q == RESP) && wr_q && !reject;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_array[idx_q][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign ReadData    = rdata_q;
    assign MemReady    = ready_q;
    assign MemBusy     = busy_q;
    assign MisalignErr = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: one instance with one wait state,
// one with none, sharing clock and reset.
module tb_unified_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0;
    logic [2:0]  sz1 = F3_W;
    logic [31:0] rdata1;
    logic        ready1, busy1, err1;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic [2:0]  sz0 = F3_W;
    logic [31:0] rdata0;
    logic        ready0, busy0, err0;

    int errors = 0;
    int checks = 0;
    int lat;
    logic bsy;

    always #5 clk = ~clk;

    unified_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd1), .MemWrite(wr1), .Address(addr1),
        .WriteData(wd1), .Size(sz1), .ReadData(rdata1), .MemReady(ready1),
        .MemBusy(busy1), .MisalignErr(err1)
    );

    unified_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemRead(rd0), .MemWrite(wr0), .Address(addr0),
        .WriteData(wd0), .Size(sz0), .ReadData(rdata0), .MemReady(ready0),
        .MemBusy(busy0), .MisalignErr(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the single-wait-state instance; returns edges from accept to MemReady.
    task automatic acc1(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz,
                        output int edges, output logic busy_after_accept);
        @(negedge clk);
        rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; sz1 = sz;
        @(posedge clk); #1;
        rd1 = 1'b0; wr1 = 1'b0;
        busy_after_accept = busy1;
        edges = 0;
        while (!ready1 && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    initial begin
        #12;
        chk("reset_rdata", rdata1, 32'h0);
        chk("reset_ready", {31'h0, ready1}, 32'h0);
        chk("reset_busy",  {31'h0, busy1}, 32'h0);
        chk("reset_err",   {31'h0, err1}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        acc1(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, lat, bsy);
        chk("sw_busy", {31'h0, bsy}, 32'h1);
        chk("sw_latency", lat, 2);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_W, lat, bsy);
        chk("lw_latency", lat, 2);
        chk("lw_data", rdata1, 32'hDEADBEEF);
        chk("lw_err", {31'h0, err1}, 32'h0);
        chk("lw_busy_at_ready", {31'h0, busy1}, 32'h0);

        acc1(1'b0, 1'b1, 32'h10, 32'h11223344, F3_W, lat, bsy);
        acc1(1'b0, 1'b1, 32'h13, 32'hAAAAAA7F, F3_B, lat, bsy);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_W, lat, bsy);
        chk("sb_merge", rdata1, 32'h7F223344);
        acc1(1'b1, 1'b0, 32'h13, 32'h0, F3_B, lat, bsy);
        chk("lb_pos", rdata1, 32'h0000007F);
        acc1(1'b0, 1'b1, 32'h10, 32'h00000080, F3_B, lat, bsy);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_B, lat, bsy);
        chk("lb_neg", rdata1, 32'hFFFFFF80);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_BU, lat, bsy);
        chk("lbu", rdata1, 32'h00000080);
        acc1(1'b0, 1'b1, 32'h12, 32'h55558001, F3_H, lat, bsy);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_W, lat, bsy);
        chk("sh_merge", rdata1, 32'h80013380);
        acc1(1'b1, 1'b0, 32'h12, 32'h0, F3_H, lat, bsy);
        chk("lh_neg", rdata1, 32'hFFFF8001);
        acc1(1'b1, 1'b0, 32'h12, 32'h0, F3_HU, lat, bsy);
        chk("lhu", rdata1, 32'h00008001);

        acc1(1'b1, 1'b0, 32'h11, 32'h0, F3_H, lat, bsy);
        chk("lh_mis_data", rdata1, 32'h0);
        chk("lh_mis_err", {31'h0, err1}, 32'h1);
        chk("lh_mis_ready", {31'h0, ready1}, 32'h1);
        @(posedge clk); #1;
        chk("err_pulse_end", {31'h0, err1}, 32'h0);
        acc1(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, F3_W, lat, bsy);
        chk("sw_mis_err", {31'h0, err1}, 32'h1);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_W, lat, bsy);
        chk("sw_mis_nowrite", rdata1, 32'h80013380);
        acc1(1'b0, 1'b1, 32'h10, 32'h000000FF, F3_BU, lat, bsy);
        chk("sbu_reject", {31'h0, err1}, 32'h1);
        acc1(1'b1, 1'b0, 32'h10, 32'h0, F3_W, lat, bsy);
        chk("sbu_nowrite", rdata1, 32'h80013380);

        acc1(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, F3_W, lat, bsy);
        chk("both_hold_rdata", rdata1, 32'h80013380);
        chk("both_err", {31'h0, err1}, 32'h0);

        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h20; sz1 = F3_W;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held_ready", {31'h0, ready1}, 32'h1);
        chk("held_data", rdata1, 32'hA5A5A5A5);
        chk("held_idle_busy", {31'h0, busy1}, 32'h0);
        @(posedge clk); #1;
        chk("held_rearm_busy", {31'h0, busy1}, 32'h1);
        rd1 = 1'b0;
        lat = 0;
        while (!ready1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held_second_lat", lat, 2);

        acc1(1'b0, 1'b1, 32'h30, 32'h12345678, F3_W, lat, bsy);
        @(negedge clk);
        wr1 = 1'b1; addr1 = 32'h30; wd1 = 32'h00000055; sz1 = F3_W;
        @(posedge clk); #1;
        wr1 = 1'b0;
        chk("abort_busy", {31'h0, busy1}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_rdata", rdata1, 32'h0);
        chk("abort_ready", {31'h0, ready1}, 32'h0);
        chk("abort_busy0", {31'h0, busy1}, 32'h0);
        chk("abort_err", {31'h0, err1}, 32'h0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        acc1(1'b1, 1'b0, 32'h30, 32'h0, F3_W, lat, bsy);
        chk("abort_nowrite", rdata1, 32'h12345678);
        acc1(1'b1, 1'b0, 32'h430, 32'h0, F3_W, lat, bsy);
        chk("alias_read", rdata1, 32'h12345678);

        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h0; wd0 = 32'hCAFEF00D; sz0 = F3_W;
        @(posedge clk); #1;
        wr0 = 1'b0;
        @(posedge clk); #1;
        chk("w0_sw_ready", {31'h0, ready0}, 32'h1);
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h0; sz0 = F3_W;
        @(posedge clk); #1;
        rd0 = 1'b0;
        chk("w0_busy", {31'h0, busy0}, 32'h1);
        chk("w0_not_ready", {31'h0, ready0}, 32'h0);
        @(posedge clk); #1;
        chk("w0_ready", {31'h0, ready0}, 32'h1);
        chk("w0_busy_done", {31'h0, busy0}, 32'h0);
        chk("w0_fetch", rdata0, 32'hCAFEF00D);
        chk("w0_err", {31'h0, err0}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
